can_rx_frame_fifo: RTL and testbench

Receive frame buffer sitting directly downstream of the acceptance filter in the SJA1000-compatible controller. It stores received frame bytes (frame info, ID, data) from the bit stream processor, and commits or discards each frame on the filter's verdict. It exposes the head frame to the register file as a random-access receive window and tracks the RX message count (RMC).
- Release Receive Buffer advances to the next frame.
- A 64-byte data RAM plus a 64-entry length FIFO, as in SJA1000.

---
 rtl/can_rx_pkg.sv | 11 +
 rtl/can_rx_len_fifo.sv | 57 +++++
 rtl/can_rx_frame_fifo.sv | 151 +++++++++++++++
 tb/tb_can_rx_frame_fifo.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/can_rx_pkg.sv
// Shared constants and types for the CAN receive frame buffer.
package can_rx_pkg;

  localparam int CAN_RX_FIFO_BYTES   = 64;
  localparam int CAN_RX_INFO_ENTRIES = 64;
  localparam int CAN_MAX_FRAME_BYTES = 13;

  typedef logic [6:0] ptr_t;
  typedef logic [3:0] flen_t;

endpackage

// File: rtl/can_rx_len_fifo.sv
// Length FIFO: one entry per committed frame, head is the oldest length.
module can_rx_len_fifo
  import can_rx_pkg::*;
#(
  parameter int AW = 6,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [LW-1:0] push_len,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] head
);

  logic [LW-1:0] mem [2**AW];
  logic [AW:0]   wp_q, wp_d;
  logic [AW:0]   rp_q, rp_d;
  logic          do_push, do_pop;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign head  = mem[rp_q[AW-1:0]];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (do_push) wp_d = wp_q + 1'b1;
    if (do_pop)  rp_d = rp_q + 1'b1;
    if (flush) begin
      wp_d = '0;
      rp_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp_q[AW-1:0]] <= push_len;
  end

endmodule

// File: rtl/can_rx_frame_fifo.sv
// CAN receive frame buffer: speculative byte writes, commit/abort, head window.
// CAN_RX_FIFO_REG_RDATA_EN registers rd_data (one cycle latency).
module can_rx_frame_fifo
  import can_rx_pkg::*;
#(
  parameter int DATA_AW         = $clog2(CAN_RX_FIFO_BYTES),
  parameter int INFO_AW         = $clog2(CAN_RX_INFO_ENTRIES),
  parameter int MAX_FRAME_BYTES = CAN_MAX_FRAME_BYTES
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           reset_mode,
  input  logic           wr,
  input  logic [7:0]     wr_data,
  input  logic           frame_commit,
  input  logic           frame_abort,
  input  logic           release_buffer,
  input  logic [3:0]     rd_offset,
  output logic [7:0]     rd_data,
  output logic [INFO_AW:0] frame_count,
  output logic           buffer_status,
  output logic           data_overrun,
  input  logic           clear_overrun
);

  localparam int LW = $clog2(MAX_FRAME_BYTES + 1);

  logic [7:0]      ram [2**DATA_AW];
  logic [DATA_AW:0] rd_q, rd_d;
  logic [DATA_AW:0] cm_q, cm_d;
  logic [DATA_AW:0] sp_q, sp_d;
  logic [DATA_AW:0] used, sp_eff;
  logic [LW-1:0]   len_q, len_d, len_eff, head;
  logic [INFO_AW:0] cnt_q, cnt_d;
  logic            ovp_q, ovp_d;
  logic            dov_q, dov_d;
  logic            data_full, len_full, len_empty;
  logic            wr_acc, ovr_eff, do_push, do_pop, ovr_set, close;
  logic [DATA_AW-1:0] ra;
  logic [7:0]      ram_rd;

  assign used      = sp_q - rd_q;
  assign data_full = used[DATA_AW];

  always_comb begin
    wr_acc  = wr && !data_full && !len_full && !ovp_q;
    ovr_eff = ovp_q || (wr && (data_full || len_full));
    sp_eff  = sp_q + (DATA_AW+1)'(wr_acc);
    len_eff = len_q + LW'(wr_acc);
    close   = frame_commit || frame_abort;
    do_pop  = release_buffer && (cnt_q != '0);
    do_push = frame_commit && !frame_abort &&
              (len_eff != '0) && !ovr_eff;
    ovr_set = frame_commit && !frame_abort &&
              (len_eff != '0) && ovr_eff;
  end

  always_comb begin
    rd_d  = rd_q;
    cm_d  = cm_q;
    sp_d  = sp_eff;
    len_d = len_eff;
    ovp_d = ovr_eff;
    cnt_d = cnt_q;
    dov_d = dov_q;
    // A closing frame restarts at the commit pointer unless it was accepted
    if (close) begin
      len_d = '0;
      ovp_d = 1'b0;
      if (frame_abort || ovr_set) sp_d = cm_q;
      if (do_push) cm_d = sp_eff;
    end
    if (do_pop) rd_d = rd_q + (DATA_AW+1)'(head);
    if (do_push && !do_pop)     cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    if (ovr_set)            dov_d = 1'b1;
    else if (clear_overrun) dov_d = 1'b0;
    if (reset_mode) begin
      rd_d  = '0;
      cm_d  = '0;
      sp_d  = '0;
      len_d = '0;
      ovp_d = 1'b0;
      cnt_d = '0;
      dov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      cm_q  <= '0;
      sp_q  <= '0;
      len_q <= '0;
      ovp_q <= 1'b0;
      cnt_q <= '0;
      dov_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      cm_q  <= cm_d;
      sp_q  <= sp_d;
      len_q <= len_d;
      ovp_q <= ovp_d;
      cnt_q <= cnt_d;
      dov_q <= dov_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !reset_mode) ram[sp_q[DATA_AW-1:0]] <= wr_data;
  end

  can_rx_len_fifo #(
    .AW (INFO_AW),
    .LW (LW)
  ) u_len_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (reset_mode),
    .push     (do_push),
    .push_len (len_eff),
    .pop      (do_pop),
    .full     (len_full),
    .empty    (len_empty),
    .head     (head)
  );

  assign ra     = rd_q[DATA_AW-1:0] + DATA_AW'(rd_offset);
  assign ram_rd = ram[ra];

`ifdef CAN_RX_FIFO_REG_RDATA_EN
  logic [7:0] rdat_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rdat_q <= '0;
    else if (reset_mode) rdat_q <= '0;
    else                 rdat_q <= ram_rd;
  end
  assign rd_data = rdat_q;
`else
  // Empty buffer reads zero so a flushed controller shows a clean window
  assign rd_data = (reset_mode || cnt_q == '0) ? 8'h00 : ram_rd;
`endif

  assign frame_count   = cnt_q;
  assign buffer_status = (cnt_q != '0);
  assign data_overrun  = dov_q;

  logic unused_ok;
  assign unused_ok = len_empty;

endmodule

// File: tb/tb_can_rx_frame_fifo.sv
// Directed bench for can_rx_frame_fifo.
module tb_can_rx_frame_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       reset_mode = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] wr_data = '0;
  logic       frame_commit = 1'b0;
  logic       frame_abort = 1'b0;
  logic       release_buffer = 1'b0;
  logic [3:0] rd_offset = '0;
  logic [7:0] rd_data;
  logic [6:0] frame_count;
  logic       buffer_status;
  logic       data_overrun;
  logic       clear_overrun = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  can_rx_frame_fifo dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .reset_mode     (reset_mode),
    .wr             (wr),
    .wr_data        (wr_data),
    .frame_commit   (frame_commit),
    .frame_abort    (frame_abort),
    .release_buffer (release_buffer),
    .rd_offset      (rd_offset),
    .rd_data        (rd_data),
    .frame_count    (frame_count),
    .buffer_status  (buffer_status),
    .data_overrun   (data_overrun),
    .clear_overrun  (clear_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    wr = 1'b1;
    wr_data = b;
    tick();
    wr = 1'b0;
  endtask

  task automatic commit();
    frame_commit = 1'b1;
    tick();
    frame_commit = 1'b0;
  endtask

  task automatic abort();
    frame_abort = 1'b1;
    tick();
    frame_abort = 1'b0;
  endtask

  task automatic rel();
    release_buffer = 1'b1;
    tick();
    release_buffer = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] off,
                        input logic [7:0] exp);
    rd_offset = off;
    #1;
    chk(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic frame13(input logic [7:0] base);
    for (int k = 0; k < 13; k++) wr_byte(base + 8'(k));
    commit();
  endtask

  logic [7:0] f1 [5] = '{8'h08, 8'h24, 8'h60, 8'h00, 8'h00};

  initial begin
    tick();
    tick();
    chk("rst_cnt", 32'(frame_count), 0);
    chk("rst_bs", 32'(buffer_status), 0);
    chk("rst_ovr", 32'(data_overrun), 0);
    chk("rst_rd", 32'(rd_data), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) wr_byte(f1[i]);
    commit();
    chk("t1_cnt", 32'(frame_count), 1);
    chk("t1_bs", 32'(buffer_status), 1);
    for (int i = 0; i < 5; i++) rd_chk("t1_rd", 4'(i), f1[i]);
    rel();
    chk("t1_rel", 32'(frame_count), 0);
    chk("t1_bs0", 32'(buffer_status), 0);

    for (int i = 0; i < 7; i++) wr_byte(8'h11 + 8'(i));
    abort();
    chk("t2_abort", 32'(frame_count), 0);
    wr_byte(8'hA1);
    wr_byte(8'hA2);
    wr_byte(8'hA3);
    commit();
    chk("t2_cnt", 32'(frame_count), 1);
    rd_chk("t2_rd0", 0, 8'hA1);
    rd_chk("t2_rd2", 2, 8'hA3);
    rel();

    for (int f = 1; f <= 5; f++) frame13(8'(f) << 4);
    chk("t3_ovr", 32'(data_overrun), 1);
    chk("t3_cnt", 32'(frame_count), 4);
    rd_chk("t3_head", 0, 8'h10);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("t3_clr", 32'(data_overrun), 0);

    rel();
    frame13(8'h60);
    chk("t4_cnt", 32'(frame_count), 4);
    rd_chk("t4_head", 0, 8'h20);
    rel();
    rel();
    rel();
    chk("t4_cnt1", 32'(frame_count), 1);
    for (int k = 0; k < 13; k++) rd_chk("t4_wrap", 4'(k), 8'h60 + 8'(k));

    wr_byte(8'h71);
    wr_byte(8'h72);
    wr_byte(8'h73);
    commit();
    chk("t5_cnt2", 32'(frame_count), 2);
    wr_byte(8'h81);
    wr = 1'b1;
    wr_data = 8'h82;
    frame_commit = 1'b1;
    release_buffer = 1'b1;
    tick();
    wr = 1'b0;
    frame_commit = 1'b0;
    release_buffer = 1'b0;
    chk("t5_cnt", 32'(frame_count), 2);
    rd_chk("t5_head", 0, 8'h71);
    rel();
    rd_chk("t5_nx0", 0, 8'h81);
    rd_chk("t5_nx1", 1, 8'h82);

    wr_byte(8'h91);
    commit();
    wr_byte(8'h92);
    commit();
    chk("t6_cnt3", 32'(frame_count), 3);
    reset_mode = 1'b1;
    tick();
    reset_mode = 1'b0;
    chk("t6_cnt", 32'(frame_count), 0);
    chk("t6_bs", 32'(buffer_status), 0);
    chk("t6_ovr", 32'(data_overrun), 0);

    wr_byte(8'hC1);
    commit();
    chk("t7_cnt1", 32'(frame_count), 1);
    wr = 1'b1;
    wr_data = 8'hC2;
    #3;
    rst_n = 1'b0;
    #1;
    chk("t7_acnt", 32'(frame_count), 0);
    chk("t7_abs", 32'(buffer_status), 0);
    chk("t7_ard", 32'(rd_data), 0);
    wr = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    wr_byte(8'hB1);
    commit();
    rd_chk("t7_rd0", 0, 8'hB1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
